// File: rtl/cyber_player.sv
// Computer opponent for Cyber War: issues one-clock press pulses when a
// 10-bit LFSR falls below the difficulty setting, with a refractory gap.
module cyber_player #(
  parameter int unsigned LFSR_W = 10,
  parameter int unsigned GAP    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              freeze,
  input  logic [8:0]        SW,
  output logic              press,
  output logic [LFSR_W-1:0] lfsr
);

  localparam int unsigned       CNT_W = $clog2(GAP + 1);
  localparam logic [CNT_W-1:0]  GAP_C = CNT_W'(GAP);
  localparam logic [LFSR_W-1:0] SEED  = LFSR_W'(1);

  logic [LFSR_W-1:0] r_lfsr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_press;

  logic [LFSR_W-1:0] w_lfsr_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_press_nxt;
  logic              w_req;

  always_comb begin
    w_lfsr_nxt  = r_lfsr;
    w_cnt_nxt   = r_cnt;
    w_press_nxt = 1'b0;
    // Request compares against the pre-update LFSR value.
    w_req       = (r_lfsr < LFSR_W'(SW));
    if (tick) begin
      if (r_lfsr == '0)
        w_lfsr_nxt = SEED;
      else
        w_lfsr_nxt = {r_lfsr[LFSR_W-2:0], r_lfsr[9] ^ r_lfsr[6]};

      if (freeze) begin
        w_cnt_nxt = '0;
      end else if (r_cnt != '0) begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
      end else if (w_req) begin
        w_press_nxt = 1'b1;
        w_cnt_nxt   = GAP_C;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lfsr  <= SEED;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_lfsr  <= w_lfsr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_press <= w_press_nxt;
    end
  end

  assign press = r_press;
  assign lfsr  = r_lfsr;

endmodule

// File: tb/tb_cyber_player.sv
// Self-checking bench for cyber_player: directed scenarios plus randomized
// traffic checked against a tick-counting reference model.
module tb_cyber_player;

  localparam int GAP = 2;
  localparam int BIG = 1 << 20;

  logic       clk;
  logic       reset;
  logic       tick;
  logic       freeze;
  logic [8:0] SW;
  logic       press;
  logic [9:0] lfsr;

  int n_total;
  int n_bad;

  // Reference model: LFSR as an integer, gap as "ticks since last press".
  int m_lfsr;
  int m_since;
  int m_press;

  cyber_player #(.LFSR_W(10), .GAP(GAP)) dut (
    .clk    (clk),
    .reset  (reset),
    .tick   (tick),
    .freeze (freeze),
    .SW     (SW),
    .press  (press),
    .lfsr   (lfsr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int lfsr_next(input int v);
    int fb;
    if (v == 0) return 1;
    fb = ((v / 512) + (v / 64)) % 2;
    return ((v * 2) % 1024) + fb;
  endfunction

  task automatic model_reset();
    m_lfsr  = 1;
    m_since = BIG;
    m_press = 0;
  endtask

  // Drive one clk cycle of inputs, update the model, sample #1 after the edge.
  task automatic cyc(input logic t, input logic f, input logic [8:0] sw);
    int req;
    tick   = t;
    freeze = f;
    SW     = sw;
    m_press = 0;
    if (t) begin
      req = (m_lfsr < int'(sw)) ? 1 : 0;
      if (m_since < BIG) m_since++;
      if (f) begin
        m_since = BIG;
      end else if (m_since > GAP && req == 1) begin
        m_press = 1;
        m_since = 0;
      end
      m_lfsr = lfsr_next(m_lfsr);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    tick = 1'b1; freeze = 1'b0; SW = 9'h1FF;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    n_total++;
    if (press !== 1'b0) begin
      n_bad++; $display("FAIL reset_press: got %b want 0", press);
    end
    n_total++;
    if (lfsr !== 10'h001) begin
      n_bad++; $display("FAIL reset_lfsr: got %h want 001", lfsr);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_lfsr_period();
    int exp_seq[8];
    int first_ret;
    exp_seq = '{1, 2, 4, 8, 16, 32, 64, 129};
    apply_reset();
    first_ret = -1;
    n_total++;
    if (lfsr !== 10'(exp_seq[0])) begin
      n_bad++; $display("FAIL period_seed: got %h want %h", lfsr, exp_seq[0]);
    end
    for (int k = 1; k <= 1023; k++) begin
      cyc(1'b1, 1'b0, 9'h000);
      if (k < 8) begin
        n_total++;
        if (lfsr !== 10'(exp_seq[k])) begin
          n_bad++; $display("FAIL period_seq%0d: got %h want %h", k, lfsr, exp_seq[k]);
        end
      end
      n_total++;
      if (lfsr !== 10'(m_lfsr) || lfsr === 10'h000 || press !== 1'b0) begin
        n_bad++;
        $display("FAIL period_step%0d: lfsr %h press %b want lfsr %h press 0", k, lfsr, press, m_lfsr);
      end
      if (lfsr === 10'h001 && first_ret < 0) first_ret = k;
    end
    n_total++;
    if (first_ret != 1023) begin
      n_bad++; $display("FAIL period_len: got %0d want 1023", first_ret);
    end
  endtask

  task automatic run_max_rate(input string tag);
    logic [8:0] pat;
    pat = 9'b100100100;
    for (int k = 0; k < 9; k++) begin
      cyc(1'b1, 1'b0, 9'h1FF);
      n_total++;
      if (press !== pat[8-k] || press !== m_press[0]) begin
        n_bad++;
        $display("FAIL %s_press%0d: got %b want %b", tag, k, press, pat[8-k]);
      end
    end
  endtask

  task automatic test_max_rate();
    apply_reset();
    run_max_rate("maxrate");
  endtask

  task automatic test_sparse_tick();
    logic prev_tick, prev_press;
    int   ticks, last_press_tick;
    apply_reset();
    prev_tick = 1'b0; prev_press = 1'b0;
    ticks = 0; last_press_tick = -BIG;
    for (int c = 0; c < 80; c++) begin
      logic t;
      t = (c % 4 == 0);
      cyc(t, 1'b0, 9'h1FF);
      if (t) ticks++;
      n_total++;
      if (press !== m_press[0]) begin
        n_bad++; $display("FAIL sparse_model%0d: got %b want %b", c, press, m_press[0]);
      end
      if (press === 1'b1) begin
        n_total++;
        if (!t || prev_press || (ticks - last_press_tick) < GAP + 1) begin
          n_bad++;
          $display("FAIL sparse_shape%0d: press after tick=%b prev=%b spacing=%0d want >=%0d",
                   c, t, prev_press, ticks - last_press_tick, GAP + 1);
        end
        last_press_tick = ticks;
      end
      prev_tick  = t;
      prev_press = press;
    end
  endtask

  task automatic test_freeze();
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b1, 9'h1FF);
      n_total++;
      if (press !== 1'b0) begin
        n_bad++; $display("FAIL freeze_press%0d: got %b want 0", k, press);
      end
    end
    n_total++;
    if (lfsr !== 10'h008) begin
      n_bad++; $display("FAIL freeze_lfsr: got %h want 008", lfsr);
    end
    cyc(1'b1, 1'b0, 9'h1FF);
    n_total++;
    if (press !== 1'b1) begin
      n_bad++; $display("FAIL freeze_release: got %b want 1", press);
    end
  endtask

  task automatic test_hold();
    logic [9:0] saved;
    cyc(1'b1, 1'b0, 9'h0A5);
    saved = lfsr;
    for (int k = 0; k < 20; k++) begin
      cyc(1'b0, 1'b0, 9'h1FF);
      n_total++;
      if (lfsr !== saved || press !== 1'b0) begin
        n_bad++;
        $display("FAIL hold%0d: lfsr %h press %b want lfsr %h press 0", k, lfsr, press, saved);
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    cyc(1'b1, 1'b0, 9'h1FF);
    n_total++;
    if (press !== 1'b1) begin
      n_bad++; $display("FAIL areset_pre: got %b want 1", press);
    end
    #2;
    reset = 1'b0;
    #1;
    n_total++;
    if (press !== 1'b0 || lfsr !== 10'h001) begin
      n_bad++; $display("FAIL areset_mid: press %b lfsr %h want 0 001", press, lfsr);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    run_max_rate("areset");
  endtask

  task automatic test_random();
    logic [8:0] sw;
    logic       prev_press;
    apply_reset();
    sw = 9'h100;
    prev_press = 1'b0;
    for (int c = 0; c < 600; c++) begin
      logic t, f;
      if ($urandom_range(0, 29) == 0) begin
        case ($urandom_range(0, 3))
          0: sw = 9'h000;
          1: sw = 9'h1FF;
          default: sw = 9'($urandom);
        endcase
      end
      t = ($urandom_range(0, 2) != 0);
      f = ($urandom_range(0, 11) == 0);
      cyc(t, f, sw);
      n_total++;
      if (press !== m_press[0] || lfsr !== 10'(m_lfsr) || (press && prev_press)) begin
        n_bad++;
        $display("FAIL random%0d: press %b lfsr %h want press %0d lfsr %h",
                 c, press, lfsr, m_press, m_lfsr);
      end
      prev_press = press;
    end
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    reset   = 1'b1;
    tick    = 1'b0;
    freeze  = 1'b0;
    SW      = '0;
    model_reset();
    test_reset();
    test_lfsr_period();
    test_max_rate();
    test_sparse_tick();
    test_freeze();
    test_hold();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
